// File: rtl/shot_link_initiator.sv
// Initiator side of the inter-board shot link: frames a fire request as
// header + position bytes on the UART TX stream, then waits for the opponent's
// result byte. It retransmits the frame when no response arrives and raises
// link_err once every attempt has timed out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no shot in flight, waiting for an in-range fire request
// SEND_HDR  | presenting HDR_BYTE on tx_data until the UART accepts it
// SEND_POS  | presenting the latched position until the UART accepts it
// WAIT_RESP | timing the opponent's response window for this attempt
module shot_link_initiator #(
    parameter logic [7:0] HDR_BYTE       = 8'hA5,
    parameter logic [5:0] RESP_TAG       = 6'b110000,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire,
    input  logic [7:0] fire_pos,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] result_code,
    output logic [7:0] result_pos,
    output logic       link_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_POS,
        WAIT_RESP
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    pos_q, pos_nxt;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          res_valid_nxt;
    logic [1:0]    res_code_nxt;
    logic [7:0]    res_pos_nxt;
    logic          link_err_nxt;

    logic pos_ok;
    logic resp_ok;
    logic timeout;

    assign pos_ok  = (fire_pos[7:4] <= 4'd9) && (fire_pos[3:0] <= 4'd9);
    assign resp_ok = rx_valid && (rx_data[7:2] == RESP_TAG) && (rx_data[1:0] != 2'b01);
    assign timeout = (tmo_cnt == TMO_LAST);
    assign busy    = (state != IDLE);

    // Next-state, counter updates and TX byte selection; a valid response
    // takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_nxt     = state;
        pos_nxt       = pos_q;
        retry_nxt     = retry_cnt;
        tmo_nxt       = tmo_cnt;
        res_valid_nxt = 1'b0;
        res_code_nxt  = result_code;
        res_pos_nxt   = result_pos;
        link_err_nxt  = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        case (state)
            IDLE: begin
                if (fire && pos_ok) begin
                    state_nxt = SEND_HDR;
                    pos_nxt   = fire_pos;
                    retry_nxt = '0;
                end
            end
            SEND_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) begin
                    state_nxt = SEND_POS;
                end
            end
            SEND_POS: begin
                tx_valid = 1'b1;
                tx_data  = pos_q;
                if (tx_ready) begin
                    state_nxt = WAIT_RESP;
                    tmo_nxt   = '0;
                end
            end
            WAIT_RESP: begin
                if (resp_ok) begin
                    state_nxt     = IDLE;
                    res_valid_nxt = 1'b1;
                    res_code_nxt  = rx_data[1:0];
                    res_pos_nxt   = pos_q;
                end else if (timeout) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt    = IDLE;
                        link_err_nxt = 1'b1;
                    end else begin
                        state_nxt = SEND_HDR;
                        retry_nxt = retry_cnt + 1'b1;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched position, counters and registered result/error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q        <= 8'h00;
            retry_cnt    <= '0;
            tmo_cnt      <= '0;
            result_valid <= 1'b0;
            result_code  <= 2'b00;
            result_pos   <= 8'h00;
            link_err     <= 1'b0;
        end else begin
            pos_q        <= pos_nxt;
            retry_cnt    <= retry_nxt;
            tmo_cnt      <= tmo_nxt;
            result_valid <= res_valid_nxt;
            result_code  <= res_code_nxt;
            result_pos   <= res_pos_nxt;
            link_err     <= link_err_nxt;
        end
    end

endmodule
